fsm_counter_dispatcher: RTL

//   Upstream stage of the FSM counter: queues count requests in a small FIFO and

---
 rtl/fsm_counter_dispatcher.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fsm_counter_dispatcher.sv
// Request FIFO plus launch FSM feeding the FSM counter's i_run/i_num_cnt
// interface, with a retired-job counter and a sticky watchdog flag.
module fsm_counter_dispatcher #(
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_req_valid,
  input  logic [CNT_W-1:0]         i_req_num,
  output logic                     o_req_ready,
  output logic                     o_cnt_run,
  output logic [CNT_W-1:0]         o_cnt_num,
  input  logic                     i_cnt_idle,
  input  logic                     i_cnt_done,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic                     o_zero_drop,
  output logic [15:0]              o_job_cnt,
  output logic                     o_timeout
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        level_q, level_d;
  logic [CNT_W-1:0]   cnt_num_q, cnt_num_d;
  logic [15:0]        job_cnt_q, job_cnt_d;
  logic               timeout_q, timeout_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               zero_drop_q;
  logic               push, store, pop;

  assign o_req_ready = (level_q != (AW+1)'(DEPTH));
  assign push        = i_req_valid && o_req_ready;
  // Zero-count requests complete the handshake but never occupy a slot.
  assign store       = push && (i_req_num != '0);
  assign pop         = (state_q == S_LAUNCH);

  always_comb begin
    level_d = level_q;
    case ({store, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= i_req_num;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      zero_drop_q <= push && (i_req_num == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_num_d = cnt_num_q;
    job_cnt_d = job_cnt_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    o_cnt_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && i_cnt_idle) begin
          state_d   = S_LAUNCH;
          cnt_num_d = mem_q[rd_ptr_q];
        end
      end
      S_LAUNCH: begin
        o_cnt_run = 1'b1;
        wd_d      = '0;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Done is tested first so it wins over a watchdog expiring on the same cycle.
        if (i_cnt_done) begin
          job_cnt_d = job_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_num_q <= '0;
      job_cnt_q <= '0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_num_q <= cnt_num_d;
      job_cnt_q <= job_cnt_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  assign o_cnt_num   = cnt_num_q;
  assign o_level     = level_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_zero_drop = zero_drop_q;
  assign o_job_cnt   = job_cnt_q;
  assign o_timeout   = timeout_q;

endmodule
